// File: rtl/gsm_mc_ram_pkg.sv
// Shared helpers for the multicast shared-memory RAM tile: width and popcount
// functions plus the default central RAM read latency.
package gsm_mc_ram_pkg;

  localparam int DEF_RD_LAT = 2;

  // Ceiling log2, never below 1 so that index vectors always have a bit.
  function automatic int clogb(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  // A reference counter must hold every copy count from 0 to MWIDTH.
  function automatic int rc_width(input int mwidth);
    return clogb(mwidth + 1);
  endfunction

endpackage

// File: rtl/gsm_mc_ram_opq.sv
// Per-egress-port pointer FIFO holding cell addresses awaiting service.
// The head entry is presented combinationally; pushes become visible next cycle.
module gsm_mc_ram_opq
  import gsm_mc_ram_pkg::*;
#(
  parameter int AWIDTH  = 9,
  parameter int QAWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [AWIDTH-1:0] push_addr,
  input  logic              pop,
  output logic [AWIDTH-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << QAWIDTH;

  logic [AWIDTH-1:0]  slots [DEPTH];
  logic [QAWIDTH-1:0] wr_ptr;
  logic [QAWIDTH-1:0] rd_ptr;
  logic [QAWIDTH:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (QAWIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + QAWIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + QAWIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (QAWIDTH+1)'(1);
        2'b01:   count <= count - (QAWIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays are not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_addr;
  end

endmodule

// File: rtl/gsm_mc_ram.sv
// Multicast shared-memory RAM tile: central cell store, per-port pointer queues,
// round-robin egress scheduler and per-cell reference counters that release cells.
// Optional feature macro GSM_MC_OCC_EN adds the o_cells_used live-cell counter.
module gsm_mc_ram
  import gsm_mc_ram_pkg::*;
#(
  parameter int MWIDTH  = 4,
  parameter int DWIDTH  = 128,
  parameter int AWIDTH  = 9,
  parameter int QAWIDTH = 4,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              i_wr_en,
  input  logic [AWIDTH-1:0] i_wr_addr,
  input  logic [DWIDTH-1:0] i_wr_data,
  input  logic [MWIDTH-1:0] i_multicast,
  output logic              o_wr_ready,
  input  logic [MWIDTH-1:0] i_egress_stall,
  output logic              o_egress_valid,
  output logic [MWIDTH-1:0] o_egress_sel,
  output logic [DWIDTH-1:0] o_egress_data,
  output logic              o_buf_free,
  output logic [AWIDTH-1:0] o_buf_free_addr
`ifdef GSM_MC_OCC_EN
  ,
  output logic [AWIDTH:0]   o_cells_used
`endif
);

  localparam int NCELL = 1 << AWIDTH;
  localparam int RC_W  = rc_width(MWIDTH);
  localparam int PW    = clogb(MWIDTH);
  localparam int LAST  = RD_LAT - 1;

  logic [MWIDTH-1:0] q_full;
  logic [MWIDTH-1:0] q_empty;
  logic [MWIDTH-1:0] q_pop;
  logic [MWIDTH-1:0] req;
  logic [AWIDTH-1:0] q_head [MWIDTH];

  logic              wr_acc;
  logic              wr_store;
  logic              zf_acc;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [AWIDTH-1:0] gnt_addr;

  logic [RC_W-1:0]   refcnt [NCELL];
  logic [DWIDTH-1:0] mem    [NCELL];

  logic [RD_LAT-1:0] p_valid;
  logic [RD_LAT-1:0] p_free;
  logic [MWIDTH-1:0] p_sel  [RD_LAT];
  logic [AWIDTH-1:0] p_addr [RD_LAT];
  logic [DWIDTH-1:0] p_data [RD_LAT];

  logic              real_free;
  logic              zf_pend;
  logic [AWIDTH-1:0] zf_addr;

  assign real_free = p_free[LAST];

  // A deferred zero-fanout release blocks ingress until its register drains.
  assign o_wr_ready = ~|(i_multicast & q_full) & ~(zf_pend & real_free);
  assign wr_acc     = i_wr_en & o_wr_ready & ~clr;
  assign wr_store   = wr_acc & (|i_multicast);
  assign zf_acc     = wr_acc & ~(|i_multicast);

  for (genvar k = 0; k < MWIDTH; k++) begin : g_q
    gsm_mc_ram_opq #(
      .AWIDTH  (AWIDTH),
      .QAWIDTH (QAWIDTH)
    ) u_opq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .push      (wr_acc & i_multicast[k]),
      .push_addr (i_wr_addr),
      .pop       (q_pop[k]),
      .head      (q_head[k]),
      .full      (q_full[k]),
      .empty     (q_empty[k])
    );
  end

  assign req = ~q_empty & ~i_egress_stall;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < MWIDTH; i++) begin
      if (!gnt_any && req[(int'(rr_ptr) + i) % MWIDTH]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'((int'(rr_ptr) + i) % MWIDTH);
      end
    end
  end

  assign q_pop    = gnt_any ? (MWIDTH'(1) << gnt_idx) : '0;
  assign gnt_addr = q_head[gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (clr) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= PW'((int'(gnt_idx) + 1) % MWIDTH);
    end
  end

  // Reference counters live in flops; a write and a grant never hit the same live cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCELL; i++) refcnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCELL; i++) refcnt[i] <= '0;
    end else begin
      if (gnt_any)  refcnt[gnt_addr]  <= refcnt[gnt_addr] - RC_W'(1);
      if (wr_store) refcnt[i_wr_addr] <= RC_W'(popcount(32'(i_multicast)));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_store) mem[i_wr_addr] <= i_wr_data;
  end

  // Read pipeline: stage 0 captures the RAM word at grant, LAST drives the egress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= '0;
      p_free  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        p_sel[i]  <= '0;
        p_addr[i] <= '0;
        p_data[i] <= '0;
      end
    end else if (clr) begin
      p_valid <= '0;
      p_free  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        p_sel[i]  <= '0;
        p_addr[i] <= '0;
        p_data[i] <= '0;
      end
    end else begin
      p_valid[0] <= gnt_any;
      p_free[0]  <= gnt_any && (refcnt[gnt_addr] == RC_W'(1));
      p_sel[0]   <= q_pop;
      p_addr[0]  <= gnt_addr;
      p_data[0]  <= mem[gnt_addr];
      for (int i = 1; i < RD_LAT; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_free[i]  <= p_free[i-1];
        p_sel[i]   <= p_sel[i-1];
        p_addr[i]  <= p_addr[i-1];
        p_data[i]  <= p_data[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_pend <= 1'b0;
      zf_addr <= '0;
    end else if (clr) begin
      zf_pend <= 1'b0;
      zf_addr <= '0;
    end else if (zf_acc) begin
      zf_pend <= 1'b1;
      zf_addr <= i_wr_addr;
    end else if (!real_free) begin
      zf_pend <= 1'b0;
    end
  end

  assign o_egress_valid  = p_valid[LAST];
  assign o_egress_sel    = p_sel[LAST];
  assign o_egress_data   = p_data[LAST];
  assign o_buf_free      = real_free | zf_pend;
  assign o_buf_free_addr = real_free ? p_addr[LAST] : (zf_pend ? zf_addr : '0);

`ifdef GSM_MC_OCC_EN
  logic [AWIDTH:0] cells_used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells_used <= '0;
    end else if (clr) begin
      cells_used <= '0;
    end else begin
      case ({wr_store, real_free})
        2'b10:   cells_used <= cells_used + (AWIDTH+1)'(1);
        2'b01:   cells_used <= cells_used - (AWIDTH+1)'(1);
        default: cells_used <= cells_used;
      endcase
    end
  end

  assign o_cells_used = cells_used;
`endif

  a_no_live_overwrite: assert property (@(posedge clk) disable iff (!rst_n || clr)
    wr_acc |-> (refcnt[i_wr_addr] == '0));

endmodule
